// File: rtl/frog_move_ctrl.sv
// -----------------------------------------------------------------------------
// frog_move_ctrl
// Per-frame movement controller for the frog sprite. Button rising edges are
// captured as a single pending hop request while the frog is idle. The request
// is applied only on frame_tick (vertical blank), so the renderer never sees a
// torn sprite. The block also enforces a hop cooldown, runs a timed respawn
// after a hit, and returns the frog to the start position after it reaches the
// goal row.
//
// Optional build macro: FROG_WRAP_EN
//   defined   - horizontal hops that leave the screen wrap to the far edge and
//               count as a move.
//   undefined - every out-of-range hop is clamped: the position stays put and
//               only the facing direction changes.
// -----------------------------------------------------------------------------
module frog_move_ctrl #(
  parameter int STEP            = 32,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int START_X         = 304,
  parameter int START_Y         = 448,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int RESPAWN_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic [1:0] direction,
  output logic       frog_visible,
  output logic       goal_pulse,
  output logic       busy
);

  // One counter serves both the cooldown and the respawn timer, so it is
  // sized for the longer of the two.
  localparam int CNT_FRAMES = (COOLDOWN_FRAMES > RESPAWN_FRAMES) ? COOLDOWN_FRAMES : RESPAWN_FRAMES;
  localparam int CNT_W      = (CNT_FRAMES > 2) ? $clog2(CNT_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESPAWN_FRAMES - 1);

  // Target arithmetic is 11 bits wide. A hop off the top or left edge then
  // wraps to a value >= 1024, which fails the upper-bound test. As a result, a
  // single unsigned compare covers both screen edges.
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] MAX_X_W = 11'(SCREEN_W - STEP);
  localparam logic [10:0] MAX_Y_W = 11'(SCREEN_H - STEP);

  localparam logic [9:0] START_X_W = 10'(START_X);
  localparam logic [9:0] START_Y_W = 10'(START_Y);

  // Direction encoding doubles as the sprite bank select.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // FSM states.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COOLDOWN = 2'd1;
  localparam logic [1:0] ST_DEAD     = 2'd2;
  localparam logic [1:0] ST_GOAL     = 2'd3;

  // Registered state.
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             req_valid_r;
  logic [1:0]       req_dir_r;
  logic [9:0]       frog_x_r;
  logic [9:0]       frog_y_r;
  logic [1:0]       dir_r;
  logic             visible_r;
  logic             goal_r;
  logic             busy_r;
  logic             btn_up_q_r;
  logic             btn_down_q_r;
  logic             btn_left_q_r;
  logic             btn_right_q_r;

  // Combinational next-state values.
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             req_valid_nxt_s;
  logic [1:0]       req_dir_nxt_s;
  logic [9:0]       frog_x_nxt_s;
  logic [9:0]       frog_y_nxt_s;
  logic [1:0]       dir_nxt_s;
  logic             visible_nxt_s;
  logic             goal_nxt_s;

  // Button edges and hop target.
  logic             up_edge_s;
  logic             down_edge_s;
  logic             left_edge_s;
  logic             right_edge_s;
  logic             edge_any_s;
  logic [1:0]       edge_dir_s;
  logic [10:0]      x_ext_s;
  logic [10:0]      y_ext_s;
  logic [10:0]      tgt_x_s;
  logic [10:0]      tgt_y_s;
  logic             in_range_s;
  logic             lands_goal_s;

  // Saturating frame counter increment. Saturation keeps a stuck counter from
  // wrapping back to zero and re-triggering a timer.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c == CNT_SAT) begin
      r = c;
    end else begin
      r = c + CNT_ONE;
    end
    return r;
  endfunction

  assign up_edge_s    = btn_up    & ~btn_up_q_r;
  assign down_edge_s  = btn_down  & ~btn_down_q_r;
  assign left_edge_s  = btn_left  & ~btn_left_q_r;
  assign right_edge_s = btn_right & ~btn_right_q_r;

  // Encode simultaneous edges with fixed priority: up > down > left > right.
  always_comb begin
    edge_any_s = 1'b1;
    edge_dir_s = DIR_UP;
    if (up_edge_s) begin
      edge_dir_s = DIR_UP;
    end else if (down_edge_s) begin
      edge_dir_s = DIR_DOWN;
    end else if (left_edge_s) begin
      edge_dir_s = DIR_LEFT;
    end else if (right_edge_s) begin
      edge_dir_s = DIR_RIGHT;
    end else begin
      edge_any_s = 1'b0;
    end
  end

  // Compute the hop target for the pending request and check it against the screen bounds.
  always_comb begin
    x_ext_s = {1'b0, frog_x_r};
    y_ext_s = {1'b0, frog_y_r};
    tgt_x_s = x_ext_s;
    tgt_y_s = y_ext_s;
    case (req_dir_r)
      DIR_UP:    tgt_y_s = y_ext_s - STEP_W;
      DIR_RIGHT: tgt_x_s = x_ext_s + STEP_W;
      DIR_DOWN:  tgt_y_s = y_ext_s + STEP_W;
      DIR_LEFT:  tgt_x_s = x_ext_s - STEP_W;
      default: begin
        tgt_x_s = x_ext_s;
        tgt_y_s = y_ext_s;
      end
    endcase
`ifdef FROG_WRAP_EN
    // A horizontal hop that leaves the screen wraps to the opposite edge.
    if ((req_dir_r == DIR_LEFT) && (tgt_x_s > MAX_X_W)) begin
      tgt_x_s = MAX_X_W;
    end else if ((req_dir_r == DIR_RIGHT) && (tgt_x_s > MAX_X_W)) begin
      tgt_x_s = 11'd0;
    end else begin
      tgt_x_s = tgt_x_s;
    end
`else
    tgt_x_s = tgt_x_s;
`endif
    in_range_s   = (tgt_x_s <= MAX_X_W) && (tgt_y_s <= MAX_Y_W);
    lands_goal_s = (tgt_y_s == 11'd0);
  end

  // Main FSM: decide the next position, direction, visibility, timer and request.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    req_valid_nxt_s = req_valid_r;
    req_dir_nxt_s   = req_dir_r;
    frog_x_nxt_s    = frog_x_r;
    frog_y_nxt_s    = frog_y_r;
    dir_nxt_s       = dir_r;
    visible_nxt_s   = visible_r;
    goal_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hit) begin
          // A hit overrides any hop that would be applied in this cycle.
          state_nxt_s     = ST_DEAD;
          visible_nxt_s   = 1'b0;
          cnt_nxt_s       = CNT_ZERO;
          req_valid_nxt_s = 1'b0;
        end else if (frame_tick && req_valid_r) begin
          dir_nxt_s       = req_dir_r;
          req_valid_nxt_s = 1'b0;
          if (in_range_s) begin
            frog_x_nxt_s = tgt_x_s[9:0];
            frog_y_nxt_s = tgt_y_s[9:0];
            cnt_nxt_s    = CNT_ZERO;
            if (lands_goal_s) begin
              goal_nxt_s  = 1'b1;
              state_nxt_s = ST_GOAL;
            end else begin
              state_nxt_s = ST_COOLDOWN;
            end
          end else begin
            // Clamped hop: the frog turns to face the edge but does not move.
            state_nxt_s = ST_IDLE;
          end
        end else if (edge_any_s) begin
          // Last press before the frame wins.
          req_valid_nxt_s = 1'b1;
          req_dir_nxt_s   = edge_dir_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COOLDOWN: begin
        if (hit) begin
          state_nxt_s     = ST_DEAD;
          visible_nxt_s   = 1'b0;
          cnt_nxt_s       = CNT_ZERO;
          req_valid_nxt_s = 1'b0;
        end else if (frame_tick) begin
          if (cnt_r == COOL_LAST) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_inc(cnt_r);
          end
        end else begin
          state_nxt_s = ST_COOLDOWN;
        end
      end
      ST_DEAD: begin
        if (frame_tick) begin
          if (cnt_r == RESP_LAST) begin
            state_nxt_s   = ST_IDLE;
            cnt_nxt_s     = CNT_ZERO;
            frog_x_nxt_s  = START_X_W;
            frog_y_nxt_s  = START_Y_W;
            dir_nxt_s     = DIR_UP;
            visible_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_inc(cnt_r);
          end
        end else begin
          state_nxt_s = ST_DEAD;
        end
      end
      ST_GOAL: begin
        if (frame_tick) begin
          state_nxt_s  = ST_IDLE;
          frog_x_nxt_s = START_X_W;
          frog_y_nxt_s = START_Y_W;
          dir_nxt_s    = DIR_UP;
        end else begin
          state_nxt_s = ST_GOAL;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a safe, visible respawn.
        state_nxt_s     = ST_IDLE;
        cnt_nxt_s       = CNT_ZERO;
        req_valid_nxt_s = 1'b0;
        frog_x_nxt_s    = START_X_W;
        frog_y_nxt_s    = START_Y_W;
        dir_nxt_s       = DIR_UP;
        visible_nxt_s   = 1'b1;
      end
    endcase
  end

  // Register FSM state, outputs and button history; rst_n restores reset values immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      req_valid_r   <= 1'b0;
      req_dir_r     <= DIR_UP;
      frog_x_r      <= START_X_W;
      frog_y_r      <= START_Y_W;
      dir_r         <= DIR_UP;
      visible_r     <= 1'b1;
      goal_r        <= 1'b0;
      busy_r        <= 1'b0;
      btn_up_q_r    <= 1'b0;
      btn_down_q_r  <= 1'b0;
      btn_left_q_r  <= 1'b0;
      btn_right_q_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      req_valid_r   <= req_valid_nxt_s;
      req_dir_r     <= req_dir_nxt_s;
      frog_x_r      <= frog_x_nxt_s;
      frog_y_r      <= frog_y_nxt_s;
      dir_r         <= dir_nxt_s;
      visible_r     <= visible_nxt_s;
      goal_r        <= goal_nxt_s;
      busy_r        <= (state_nxt_s != ST_IDLE);
      btn_up_q_r    <= btn_up;
      btn_down_q_r  <= btn_down;
      btn_left_q_r  <= btn_left;
      btn_right_q_r <= btn_right;
    end
  end

  assign frog_x       = frog_x_r;
  assign frog_y       = frog_y_r;
  assign direction    = dir_r;
  assign frog_visible = visible_r;
  assign goal_pulse   = goal_r;
  assign busy         = busy_r;

endmodule
